// File: rtl/pwm_pkg.sv
// ----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM modulator: the controller state encoding and
// the default counter width / complementary dead time.
// ----------------------------------------------------------------------------
package pwm_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEFAULT_WIDTH    = 8;
   localparam int DEFAULT_DEADTIME = 2;

endpackage

// File: rtl/tick_edge_detect.sv
// ----------------------------------------------------------------------------
// tick_edge_detect
// Turns a slow level that is synchronous to clk into a single-cycle pulse on
// each of its rising edges. The level is treated as data only; it never
// clocks anything.
//
// Ports
//   clk    in   system clock, all state on the rising edge
//   rst    in   asynchronous, active-high reset
//   level  in   slow divided clock, sampled as data
//   tick   out  one clk-cycle pulse per rising edge of level
// ----------------------------------------------------------------------------
module tick_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic level,
   output logic tick
);

   logic level_d;

   // NOTE: registers are assigned with <= so every flop samples the values
   // that existed before the edge; blocking = here would create races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_d <= 1'b0;
      end else begin
         level_d <= level;
      end
   end

   assign tick = level & ~level_d;

endmodule

// File: rtl/pwm_modulator.sv
// ----------------------------------------------------------------------------
// pwm_modulator
// Single-channel PWM generator. A period is 2^WIDTH ticks long, where a tick
// is one rising edge of CLK_781250. A new duty value is taken through a
// valid/ready handshake into a one-deep holding register and becomes active
// only at a period boundary, so a running period is never disturbed.
//
// Optional build macro: PWM_COMPLEMENT_EN adds the PWM_N complementary output
// with DEADTIME ticks of dead time on both edges. Without it, PWM_N and its
// logic do not exist and DEADTIME is not used.
//
// Parameters
//   WIDTH     duty / period counter width, period = 2^WIDTH ticks
//   DEADTIME  complementary dead time in ticks (PWM_COMPLEMENT_EN only)
//
// Ports
//   CLK_50M       in   sole clock, all state on the rising edge
//   RST           in   asynchronous, active-high reset
//   CLK_781250    in   divided clock, synchronous to CLK_50M, sampled as data
//   EN            in   run request (level)
//   DUTY          in   requested duty in ticks
//   DUTY_VALID    in   DUTY is offered
//   DUTY_READY    out  holding register is empty
//   PWM_OUT       out  modulated output
//   PERIOD_START  out  one-cycle pulse when a new duty becomes active
//   PWM_N         out  complementary output (PWM_COMPLEMENT_EN only)
// ----------------------------------------------------------------------------
module pwm_modulator
   import pwm_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int DEADTIME = DEFAULT_DEADTIME
) (
   input  logic             CLK_50M,
   input  logic             RST,
   input  logic             CLK_781250,
   input  logic             EN,
   input  logic [WIDTH-1:0] DUTY,
   input  logic             DUTY_VALID,
   output logic             DUTY_READY,
   output logic             PWM_OUT,
   output logic             PERIOD_START
`ifdef PWM_COMPLEMENT_EN
   ,
   output logic             PWM_N
`endif
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   state_t           state,          state_nxt;
   logic [WIDTH-1:0] cnt,            cnt_nxt;
   logic [WIDTH-1:0] act_duty,       act_duty_nxt;
   logic [WIDTH-1:0] pend_duty,      pend_duty_nxt;
   logic             pend_valid,     pend_valid_nxt;
   logic             period_start_q, period_start_nxt;

   logic tick;
   logic accept;
   logic wrap;

   tick_edge_detect u_tick (
      .clk   (CLK_50M),
      .rst   (RST),
      .level (CLK_781250),
      .tick  (tick)
   );

   assign DUTY_READY = ~pend_valid;
   // A load only happens while pend_valid is set, which holds READY low, so
   // a load and an accept can never fall on the same edge.
   assign accept     = DUTY_VALID & DUTY_READY;
   assign wrap       = tick && (cnt == CNT_MAX);

   always_ff @(posedge CLK_50M or posedge RST) begin
      if (RST) begin
         state          <= IDLE;
         cnt            <= '0;
         act_duty       <= '0;
         pend_duty      <= '0;
         pend_valid     <= 1'b0;
         period_start_q <= 1'b0;
      end else begin
         state          <= state_nxt;
         cnt            <= cnt_nxt;
         act_duty       <= act_duty_nxt;
         pend_duty      <= pend_duty_nxt;
         pend_valid     <= pend_valid_nxt;
         period_start_q <= period_start_nxt;
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves
      // it unassigned; that is what keeps this block from inferring latches.
      state_nxt        = state;
      cnt_nxt          = cnt;
      act_duty_nxt     = act_duty;
      pend_duty_nxt    = pend_duty;
      pend_valid_nxt   = pend_valid;
      period_start_nxt = 1'b0;

      if (accept) begin
         pend_duty_nxt  = DUTY;
         pend_valid_nxt = 1'b1;
      end

      unique case (state)
         IDLE: begin
            if (tick && EN && pend_valid) begin
               state_nxt        = RUN;
               cnt_nxt          = '0;
               act_duty_nxt     = pend_duty;
               pend_valid_nxt   = 1'b0;
               period_start_nxt = 1'b1;
            end
         end

         RUN: begin
            if (tick) begin
               // Natural WIDTH-bit rollover gives the 2^WIDTH-1 -> 0 wrap.
               cnt_nxt = cnt + 1'b1;
            end
            // EN is only looked at on the wrap, so a period always completes.
            if (wrap) begin
               if (!EN) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else if (pend_valid) begin
                  act_duty_nxt     = pend_duty;
                  pend_valid_nxt   = 1'b0;
                  period_start_nxt = 1'b1;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign PERIOD_START = period_start_q;
   assign PWM_OUT      = (state == RUN) && (cnt < act_duty);

`ifdef PWM_COMPLEMENT_EN
   // Bounds are formed at WIDTH+1 bits so act_duty+DEADTIME cannot wrap
   // around and re-enable PWM_N next to a high PWM_OUT.
   localparam logic [WIDTH:0] N_HI = (WIDTH+1)'(2**WIDTH - 1 - DEADTIME);

   logic [WIDTH:0] n_lo;
   logic [WIDTH:0] cnt_ext;

   assign n_lo    = {1'b0, act_duty} + (WIDTH+1)'(DEADTIME);
   assign cnt_ext = {1'b0, cnt};
   assign PWM_N   = (state == RUN) && (cnt_ext >= n_lo) && (cnt_ext <= N_HI);
`endif

endmodule

// File: tb/tb_pwm_modulator.sv
// ----------------------------------------------------------------------------
// tb_pwm_modulator
// Self-checking bench for pwm_modulator with WIDTH=8, DEADTIME=2. The divided
// clock input is driven at 1/4 of CLK_50M so one tick is 4 cycles and one
// period is 1024 cycles. PWM_N checks are compiled in only when
// PWM_COMPLEMENT_EN is defined.
// ----------------------------------------------------------------------------
module tb_pwm_modulator;
   import pwm_pkg::*;

   localparam int WIDTH      = 8;
   localparam int TICK_CYC   = 4;
   localparam int PERIOD_CYC = 256 * TICK_CYC;

   logic             clk_50m = 1'b0;
   logic             rst;
   logic             clk_div;
   logic             en;
   logic [WIDTH-1:0] duty;
   logic             duty_valid;
   logic             duty_ready;
   logic             pwm_out;
   logic             period_start;
`ifdef PWM_COMPLEMENT_EN
   logic             pwm_n;
`endif

   int total = 0;
   int bad   = 0;

   // Results of the most recent measure() call, all in CLK_50M samples.
   int m_high, m_first_low, m_ps;
   int m_n_high, m_n_first, m_n_last, m_overlap;

   typedef struct {
      logic [7:0] duty;
      int         exp_high_ticks;
      int         exp_n_ticks;
      int         exp_n_first_tick;
   } vec_t;

   vec_t vecs [5];

   pwm_modulator #(
      .WIDTH    (WIDTH),
      .DEADTIME (2)
   ) dut (
      .CLK_50M      (clk_50m),
      .RST          (rst),
      .CLK_781250   (clk_div),
      .EN           (en),
      .DUTY         (duty),
      .DUTY_VALID   (duty_valid),
      .DUTY_READY   (duty_ready),
      .PWM_OUT      (pwm_out),
      .PERIOD_START (period_start)
`ifdef PWM_COMPLEMENT_EN
      ,
      .PWM_N        (pwm_n)
`endif
   );

   always #5 clk_50m = ~clk_50m;

   // Divided clock: toggles every 2 cycles on the falling edge.
   initial begin
      clk_div = 1'b0;
      forever begin
         repeat (2) @(negedge clk_50m);
         clk_div = ~clk_div;
      end
   end

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Samples n falling edges starting with the current one.
   task automatic measure(input int n);
      m_high = 0; m_first_low = -1; m_ps = 0;
      m_n_high = 0; m_n_first = -1; m_n_last = -1; m_overlap = 0;
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk_50m);
         if (pwm_out === 1'b1) m_high++;
         else if (m_first_low < 0) m_first_low = i;
         if (i > 0 && period_start === 1'b1) m_ps++;
`ifdef PWM_COMPLEMENT_EN
         if (pwm_n === 1'b1) begin
            m_n_high++;
            if (m_n_first < 0) m_n_first = i;
            m_n_last = i;
            if (pwm_out === 1'b1) m_overlap++;
         end
`endif
      end
   endtask

   task automatic wait_ps(input int max_cyc, input string name, output int waited);
      logic found;
      found  = 1'b0;
      waited = 0;
      while (!found && waited < max_cyc) begin
         @(negedge clk_50m);
         waited++;
         if (period_start === 1'b1) found = 1'b1;
      end
      check({name, "_seen"}, found, 1);
   endtask

   task automatic offer(input logic [7:0] d);
      int guard;
      guard = 0;
      while (duty_ready !== 1'b1 && guard < 2 * PERIOD_CYC) begin
         @(negedge clk_50m);
         guard++;
      end
      check("offer_ready", duty_ready, 1);
      duty       = d;
      duty_valid = 1'b1;
      @(negedge clk_50m);
      duty_valid = 1'b0;
      check("accept_ready_low", duty_ready, 0);
   endtask

   initial begin
      int waited;

      vecs[0] = '{duty: 8'd64,  exp_high_ticks: 64,  exp_n_ticks: 188, exp_n_first_tick: 66};
      vecs[1] = '{duty: 8'd0,   exp_high_ticks: 0,   exp_n_ticks: 252, exp_n_first_tick: 2};
      vecs[2] = '{duty: 8'd255, exp_high_ticks: 255, exp_n_ticks: 0,   exp_n_first_tick: -1};
      vecs[3] = '{duty: 8'd1,   exp_high_ticks: 1,   exp_n_ticks: 251, exp_n_first_tick: 3};
      vecs[4] = '{duty: 8'd128, exp_high_ticks: 128, exp_n_ticks: 124, exp_n_first_tick: 130};

      rst = 1'b1; en = 1'b0; duty = '0; duty_valid = 1'b0;
      repeat (3) @(negedge clk_50m);
      check("rst_pwm_out", pwm_out, 0);
      check("rst_period_start", period_start, 0);
      check("rst_ready", duty_ready, 1);
      check("rst_state", dut.state, IDLE);
`ifdef PWM_COMPLEMENT_EN
      check("rst_pwm_n", pwm_n, 0);
`endif
      rst = 1'b0;
      @(negedge clk_50m);
      en = 1'b1;

      // Table: each duty is offered, waited for, and one full period profiled.
      for (int v = 0; v < 5; v++) begin
         offer(vecs[v].duty);
         wait_ps(PERIOD_CYC + 80, "vec_ps", waited);
         if (v == 0) check("first_ps_latency_ok", (waited <= TICK_CYC + 1), 1);
         measure(PERIOD_CYC);
         check("vec_high_cycles", m_high, vecs[v].exp_high_ticks * TICK_CYC);
         check("vec_first_low", m_first_low, vecs[v].exp_high_ticks * TICK_CYC);
         check("vec_extra_ps", m_ps, 0);
`ifdef PWM_COMPLEMENT_EN
         check("vec_n_cycles", m_n_high, vecs[v].exp_n_ticks * TICK_CYC);
         check("vec_n_overlap", m_overlap, 0);
         if (vecs[v].exp_n_ticks > 0) begin
            check("vec_n_first", m_n_first, vecs[v].exp_n_first_tick * TICK_CYC);
            check("vec_n_last", m_n_last, 253 * TICK_CYC + TICK_CYC - 1);
         end
`endif
      end

      // Handshake stall: 100 pends, 200 waits until 100 has been loaded.
      @(negedge clk_50m);
      repeat (20) @(negedge clk_50m);
      offer(8'd100);
      duty       = 8'd200;
      duty_valid = 1'b1;
      repeat (10) @(negedge clk_50m);
      check("stall_ready_low", duty_ready, 0);
      wait_ps(PERIOD_CYC + 80, "load_100", waited);
      check("ready_rise_after_load", duty_ready, 1);
      check("load_100_pwm_high", pwm_out, 1);
      @(negedge clk_50m);
      check("accept_200_ready_low", duty_ready, 0);
      duty_valid = 1'b0;
      measure(PERIOD_CYC - 1);
      check("p100_high_cycles", m_high, 100 * TICK_CYC - 1);
      check("p100_extra_ps", m_ps, 0);
      wait_ps(8, "load_200", waited);
      measure(PERIOD_CYC);
      check("p200_high_cycles", m_high, 200 * TICK_CYC);
      check("p200_first_low", m_first_low, 200 * TICK_CYC);

      // EN drop at tick 10 of a reused-200 period with 50 pending.
      @(negedge clk_50m);
      offer(8'd50);
      repeat (39) @(negedge clk_50m);
      en = 1'b0;
      measure(PERIOD_CYC - 10 * TICK_CYC);
      check("endrop_high_cycles", m_high, 190 * TICK_CYC);
      check("endrop_first_low", m_first_low, 190 * TICK_CYC);
      check("endrop_extra_ps", m_ps, 0);
      @(negedge clk_50m);
      check("idle_pwm_low", pwm_out, 0);
      check("idle_state", dut.state, IDLE);
      check("pend_retained", duty_ready, 0);
      measure(40);
      check("idle_hold_high", m_high, 0);
      check("idle_hold_ps", m_ps, 0);
      en = 1'b1;
      wait_ps(TICK_CYC + 2, "restart", waited);
      check("restart_ready", duty_ready, 1);
      measure(PERIOD_CYC);
      check("p50_high_cycles", m_high, 50 * TICK_CYC);

      // Asynchronous reset at tick 30 of a duty-128 period.
      offer(8'd128);
      wait_ps(PERIOD_CYC + 80, "load_128", waited);
      repeat (30 * TICK_CYC) @(negedge clk_50m);
      check("pre_reset_high", pwm_out, 1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_pwm_out", pwm_out, 0);
      check("async_rst_ready", duty_ready, 1);
      check("async_rst_ps", period_start, 0);
      check("async_rst_state", dut.state, IDLE);
`ifdef PWM_COMPLEMENT_EN
      check("async_rst_pwm_n", pwm_n, 0);
`endif
      @(negedge clk_50m);
      rst = 1'b0;
      measure(40);
      check("post_rst_high", m_high, 0);
      check("post_rst_ps", m_ps, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
